// File: rtl/led_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : led_ctrl
// Purpose  : Multi-channel LED controller behind an Avalon-MM slave port.
//            Each channel is off, on, blinking (programmable half-period in
//            ticks) or PWM dimmed. A heartbeat output toggles every HB_TICKS
//            ticks. The macro LED_CTRL_PWM_EN enables the PWM counter and duty
//            storage; without it mode 11 behaves as on and duty reads as 0.
// Revision : 1.0 - initial release
// ============================================================================
module led_ctrl #(
    parameter int NUM_LEDS   = 8,
    parameter int ADDR_W     = 3,
    parameter int CLK_FREQ   = 16000000,
    parameter int TICK_HZ    = 1000,
    parameter int HB_TICKS   = 500,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   address,
    input  logic                write,
    input  logic [31:0]         writedata,
    input  logic                read,
    output logic [31:0]         readdata,
    output logic [NUM_LEDS-1:0] led,
    output logic                heartbeat
);

    localparam int c_DIV = CLK_FREQ / TICK_HZ;
    localparam int c_PW  = $clog2(c_DIV);
    localparam int c_HBW = (HB_TICKS > 1) ? $clog2(HB_TICKS) : 1;
    localparam logic [c_PW-1:0]  c_PRESC_MAX = c_PW'(c_DIV - 1);
    localparam logic [c_HBW-1:0] c_HB_MAX    = c_HBW'(HB_TICKS - 1);

    logic [c_PW-1:0]     r_presc;
    logic [c_HBW-1:0]    r_hb_cnt;
    logic                w_tick;
    logic [NUM_LEDS-1:0] w_state;
    logic [31:0]         w_word [NUM_LEDS];
    logic [31:0]         w_rd_mux;
    logic                w_unused;

`ifdef LED_CTRL_PWM_EN
    logic [7:0]          r_pwm_cnt;
    assign w_unused = &{1'b0, writedata[7:2]};
`else
    assign w_unused = &{1'b0, writedata[15:2]};
`endif

    assign w_tick = (r_presc == c_PRESC_MAX);

    // Prescaler and heartbeat: one tick every DIV clocks, heartbeat toggles every HB_TICKS ticks
    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc   <= '0;
            r_hb_cnt  <= '0;
            heartbeat <= 1'b0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + c_PW'(1);
            if (w_tick) begin
                if (r_hb_cnt == c_HB_MAX) begin
                    r_hb_cnt  <= '0;
                    heartbeat <= ~heartbeat;
                end else begin
                    r_hb_cnt <= r_hb_cnt + c_HBW'(1);
                end
            end
        end
    end

`ifdef LED_CTRL_PWM_EN
    // Shared free-running PWM counter, period 256 clocks
    always_ff @(posedge clk) begin
        if (rst) r_pwm_cnt <= '0;
        else     r_pwm_cnt <= r_pwm_cnt + 8'd1;
    end
`endif

    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
        logic [1:0]  r_mode;
        logic [15:0] r_hp;
        logic [15:0] r_bcnt;
        logic        r_phase;
        logic [7:0]  w_duty;
        logic [15:0] w_hp_lim;
        logic        w_wr;
        logic        w_lit;

        assign w_wr     = write && (address == ADDR_W'(i));
        // A half-period of 0 behaves like 1
        assign w_hp_lim = (r_hp == 16'd0) ? 16'd0 : r_hp - 16'd1;

`ifdef LED_CTRL_PWM_EN
        logic [7:0] r_duty;
        assign w_duty = r_duty;

        // Duty register, loaded on channel write
        always_ff @(posedge clk) begin
            if (rst)       r_duty <= '0;
            else if (w_wr) r_duty <= writedata[15:8];
        end
`else
        assign w_duty = 8'h00;
`endif

        // Channel config and blink engine; a write restarts the blink lit, even on a tick
        always_ff @(posedge clk) begin
            if (rst) begin
                r_mode  <= '0;
                r_hp    <= '0;
                r_bcnt  <= '0;
                r_phase <= 1'b0;
            end else if (w_wr) begin
                r_mode  <= writedata[1:0];
                r_hp    <= writedata[31:16];
                r_bcnt  <= '0;
                r_phase <= 1'b1;
            end else if (w_tick) begin
                if (r_bcnt == w_hp_lim) begin
                    r_bcnt  <= '0;
                    r_phase <= ~r_phase;
                end else begin
                    r_bcnt <= r_bcnt + 16'd1;
                end
            end
        end

        // Logical LED state selected by mode
        always_comb begin
            w_lit = 1'b0;
            case (r_mode)
                2'b01:   w_lit = 1'b1;
                2'b10:   w_lit = r_phase;
`ifdef LED_CTRL_PWM_EN
                2'b11:   w_lit = (r_pwm_cnt < r_duty);
`else
                2'b11:   w_lit = 1'b1;
`endif
                default: w_lit = 1'b0;
            endcase
        end

        assign w_state[i] = w_lit;
        assign w_word[i]  = {r_hp, w_duty, 5'b00000, w_lit, r_mode};
    end

    // Read mux; addresses without a channel return 0
    always_comb begin
        w_rd_mux = '0;
        for (int k = 0; k < NUM_LEDS; k++) begin
            if (address == ADDR_W'(k)) w_rd_mux = w_word[k];
        end
    end

    // Registered read data (holds between reads) and LED pins with polarity applied
    always_ff @(posedge clk) begin
        if (rst) begin
            readdata <= '0;
            led      <= (ACTIVE_LOW != 0) ? {NUM_LEDS{1'b1}} : {NUM_LEDS{1'b0}};
        end else begin
            if (read) readdata <= w_rd_mux;
            led <= (ACTIVE_LOW != 0) ? ~w_state : w_state;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_led_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_ctrl
// Purpose  : Self-checking bench for led_ctrl with a cycle-indexed reference
//            model (tick and PWM timing derived from the elapsed edge count).
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_ctrl;

    localparam int NL  = 8;
    localparam int AW  = 4;
    localparam int DIV = 16;
    localparam int HB  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] address = '0;
    logic          write = 1'b0;
    logic [31:0]   writedata = '0;
    logic          read = 1'b0;
    logic [31:0]   readdata;
    logic [NL-1:0] led;
    logic          heartbeat;

    led_ctrl #(
        .NUM_LEDS(NL), .ADDR_W(AW), .CLK_FREQ(16000), .TICK_HZ(1000),
        .HB_TICKS(HB), .ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst(rst), .address(address), .write(write),
        .writedata(writedata), .read(read), .readdata(readdata),
        .led(led), .heartbeat(heartbeat)
    );

    always #5 clk = ~clk;

    // Edges elapsed since the last reset edge
    int cyc = 0;
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    typedef struct { int mode; int duty; int hp; int w; } cfg_t;
    typedef struct { int addr; logic [31:0] wd; logic [31:0] rd; } vec_t;

    cfg_t        cur [NL];
    cfg_t        prv [NL];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_rd = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // Logical state of a channel right after edge j
    function automatic bit st(input int j, input int ch);
        cfg_t c;
        int   hp;
        int   n;
        bit   s;
        if (j >= cur[ch].w) c = cur[ch];
        else                c = prv[ch];
        s = 1'b0;
        case (c.mode)
            1: s = 1'b1;
            2: begin
                hp = (c.hp == 0) ? 1 : c.hp;
                n  = j / DIV - c.w / DIV;          // ticks seen since the write
                s  = ((n / hp) % 2) == 0;
            end
`ifdef LED_CTRL_PWM_EN
            3: s = (j % 256) < c.duty;
`else
            3: s = 1'b1;
`endif
            default: s = 1'b0;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] model_read(input int a);
        logic [31:0] r;
        r = '0;
        if (a < NL) begin
            r[1:0]   = cur[a].mode[1:0];
            r[2]     = st(cyc, a);
            r[15:8]  = cur[a].duty[7:0];
            r[31:16] = cur[a].hp[15:0];
        end
        return r;
    endfunction

    // Advance to the next falling edge and compare every output with the model
    task automatic step();
        logic [NL-1:0] el;
        logic          eh;
        @(negedge clk);
        if (cyc == 0) begin
            el = '1;
            eh = 1'b0;
        end else begin
            for (int ch = 0; ch < NL; ch++) el[ch] = ~st(cyc - 1, ch);
            eh = (((cyc / DIV) / HB) % 2) == 1;
        end
        chk("led", 32'(led), 32'(el));
        chk("heartbeat", 32'(heartbeat), 32'(eh));
        chk("readdata", readdata, exp_rd);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int ch = 0; ch < NL; ch++) begin
            cur[ch] = '{0, 0, 0, 0};
            prv[ch] = '{0, 0, 0, 0};
        end
        exp_rd = '0;
        repeat (n) step();
        rst = 1'b0;
    endtask

    // One bus cycle; read data is the pre-write view
    task automatic bus(input bit wr, input bit rd, input int a, input logic [31:0] wd);
        if (rd) exp_rd = model_read(a);
        if (wr && a < NL) begin
            prv[a] = cur[a];
            cur[a].mode = int'(wd[1:0]);
`ifdef LED_CTRL_PWM_EN
            cur[a].duty = int'(wd[15:8]);
`else
            cur[a].duty = 0;
`endif
            cur[a].hp = int'(wd[31:16]);
            cur[a].w  = cyc + 1;
        end
        address   = a[AW-1:0];
        write     = wr;
        read      = rd;
        writedata = wd;
        step();
        write = 1'b0;
        read  = 1'b0;
    endtask

    task automatic wait_change(input int ch, output int t, output bit ok);
        logic v;
        v  = led[ch];
        ok = 1'b0;
        t  = 0;
        for (int k = 0; k < 200 && !ok; k++) begin
            step();
            if (led[ch] !== v) begin
                ok = 1'b1;
                t  = cyc;
            end
        end
    endtask

    vec_t tbl [8];

    initial begin
        int  t1, t2, lows, r, a;
        bit  ok1, ok2, seen;
        logic [31:0] wd;

        tbl[0] = '{0,  32'h0000_0001, 32'h0000_0005};
        tbl[1] = '{2,  32'h1234_00F8, 32'h1234_0000};
        tbl[2] = '{4,  32'hABCD_0006, 32'hABCD_0006};
        tbl[3] = '{5,  32'h0000_0005, 32'h0000_0005};
        tbl[4] = '{9,  32'h0000_0001, 32'h0000_0000};
        tbl[5] = '{15, 32'hFFFF_FFFF, 32'h0000_0000};
`ifdef LED_CTRL_PWM_EN
        tbl[6] = '{6,  32'h0000_8001, 32'h0000_8005};
        tbl[7] = '{7,  32'h0000_AB02, 32'h0000_AB06};
`else
        tbl[6] = '{6,  32'h0000_8001, 32'h0000_0005};
        tbl[7] = '{7,  32'h0000_AB02, 32'h0000_0006};
`endif

        // Reset state, then heartbeat timing from release
        do_reset(4);
        chk("reset_led", 32'(led), 32'h0000_00FF);
        chk("reset_rd", readdata, 32'h0);
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            step();
            if (heartbeat === 1'b1) seen = 1'b1;
        end
        chk("hb_rise_edge", seen ? cyc : -1, 64);

        // Register write/readback table
        for (int i = 0; i < 8; i++) begin
            bus(1'b1, 1'b0, tbl[i].addr, tbl[i].wd);
            bus(1'b0, 1'b1, tbl[i].addr, 32'h0);
            chk("table_rd", readdata, tbl[i].rd);
        end
        chk("ch0_on_led", 32'(led[0]), 32'h0);

        // Blink: half-period 3 ticks -> 48 clocks per phase, restart on rewrite
        bus(1'b1, 1'b0, 3, 32'h0003_0002);
        step();
        chk("blink_start", 32'(led[3]), 32'h0);
        wait_change(3, t1, ok1);
        wait_change(3, t2, ok2);
        chk("blink_period", (ok1 && ok2) ? t2 - t1 : -1, 48);
        repeat (20) step();
        bus(1'b1, 1'b0, 3, 32'h0003_0002);
        step();
        chk("blink_restart", 32'(led[3]), 32'h0);

        // PWM duty 0x40 on ch1: lit 64 of 256 clocks
        bus(1'b1, 1'b0, 1, 32'h0000_4003);
        step();
        lows = 0;
        for (int k = 0; k < 256; k++) begin
            step();
            if (led[1] === 1'b0) lows++;
        end
`ifdef LED_CTRL_PWM_EN
        chk("pwm_lit_count", lows, 64);
`else
        chk("pwm_lit_count", lows, 256);
        bus(1'b0, 1'b1, 1, 32'h0);
        chk("pwm_off_rd", readdata, 32'h0000_0007);
`endif

        // Randomised traffic against the model
        for (int k = 0; k < 2500; k++) begin
            r  = $urandom_range(0, 9);
            a  = $urandom_range(0, 9);
            wd = $urandom;
            wd[31:16] = 16'($urandom_range(0, 3));
            if (r < 2)       bus(1'b1, 1'b0, a, wd);
            else if (r < 4)  bus(1'b0, 1'b1, a, 32'h0);
            else if (r == 4) bus(1'b1, 1'b1, a, wd);
            else             step();
        end

        // Reset in the middle of blink and PWM activity
        bus(1'b1, 1'b0, 3, 32'h0003_0002);
        bus(1'b1, 1'b0, 1, 32'h0000_4003);
        repeat (30) step();
        do_reset(1);
        chk("midrst_led", 32'(led), 32'h0000_00FF);
        for (int ch = 0; ch < NL; ch++) begin
            bus(1'b0, 1'b1, ch, 32'h0);
            chk("midrst_rd", readdata, 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
